// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - M:SS BCD cook-time countdown with keypad load, pause and timed alarm
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   D            BCD digit from the keypad encoder
//   loadn        encoder load strobe, active-low; a falling edge loads one digit
//   pgt_1hz      one-cycle 1 Hz tick
//   start        start request pulse
//   stop         stop/pause request pulse
//   clear        clear time request pulse
//   door_closed  1 = door closed
//   min_ones     minutes digit (0-9)
//   sec_tens     seconds tens digit (0-5)
//   sec_ones     seconds ones digit (0-9)
//   enablen      keypad lock back to the encoder, 1 = locked
//   magnetron    magnetron drive, 1 only while cooking
//   alarm        end-of-cook alarm, high for ALARM_TICKS ticks
module microwave_timer #(
    parameter int ALARM_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       enablen,
    output logic       magnetron,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS);

    state_t     state_q, state_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       enablen_q, enablen_d;
    logic       magnetron_q, magnetron_d;
    logic       alarm_q, alarm_d;
    logic [3:0] alarm_cnt_q, alarm_cnt_d;
    logic       loadn_q, loadn_d;

    logic       load_fire;
    logic       load_ok;
    logic       time_zero;
    logic [3:0] dec_min, dec_tens, dec_ones;
    logic       dec_zero;

    // A key press is the falling edge of loadn; the edge detector runs in
    // every state so a key held through cooking cannot load on return to IDLE.
    assign load_fire = loadn_q & ~loadn;

    // Shifting a ones digit above 5 into the tens position would give an
    // invalid seconds value, so such presses are rejected along with D > 9.
    assign load_ok   = (D <= 4'd9) && (sec_ones_q <= 4'd5);

    assign time_zero = (min_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

    // BCD decrement of M:SS; only used while RUNNING, where time is never 0:00.
    always_comb begin
        dec_min  = min_ones_q;
        dec_tens = sec_tens_q;
        dec_ones = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_ones = sec_ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (sec_tens_q != 4'd0) begin
                dec_tens = sec_tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = min_ones_q - 4'd1;
            end
        end
    end

    assign dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_comb begin
        state_d     = state_q;
        min_ones_d  = min_ones_q;
        sec_tens_d  = sec_tens_q;
        sec_ones_d  = sec_ones_q;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        loadn_d     = loadn;

        case (state_q)
            IDLE: begin
                // stop wins every same-cycle conflict; in IDLE it simply
                // suppresses the other requests for that cycle.
                if (stop) begin
                    state_d = IDLE;
                end else if (start && door_closed && !time_zero) begin
                    state_d = RUNNING;
                end else if (clear) begin
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end else if (load_fire && load_ok) begin
                    min_ones_d = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = D;
                end
            end

            RUNNING: begin
                // Pausing drops any tick arriving in the same cycle.
                if (stop || !door_closed) begin
                    state_d = PAUSED;
                end else if (pgt_1hz) begin
                    min_ones_d = dec_min;
                    sec_tens_d = dec_tens;
                    sec_ones_d = dec_ones;
                    if (dec_zero) begin
                        state_d     = DONE;
                        alarm_d     = 1'b1;
                        alarm_cnt_d = 4'd0;
                    end
                end
            end

            PAUSED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!door_closed) begin
                    state_d = PAUSED;
                end else if (start) begin
                    state_d = RUNNING;
                end else if (clear) begin
                    state_d    = IDLE;
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end
            end

            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    alarm_d = 1'b0;
                end else if (pgt_1hz) begin
                    if (alarm_cnt_q + 4'd1 >= ALARM_LAST) begin
                        state_d     = IDLE;
                        alarm_d     = 1'b0;
                        alarm_cnt_d = 4'd0;
                        min_ones_d  = 4'd0;
                        sec_tens_d  = 4'd0;
                        sec_ones_d  = 4'd0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q + 4'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        enablen_d   = (state_d != IDLE);
        magnetron_d = (state_d == RUNNING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            enablen_q   <= 1'b0;
            magnetron_q <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 4'd0;
            loadn_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            min_ones_q  <= min_ones_d;
            sec_tens_q  <= sec_tens_d;
            sec_ones_q  <= sec_ones_d;
            enablen_q   <= enablen_d;
            magnetron_q <= magnetron_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
            loadn_q     <= loadn_d;
        end
    end

    assign min_ones  = min_ones_q;
    assign sec_tens  = sec_tens_q;
    assign sec_ones  = sec_ones_q;
    assign enablen   = enablen_q;
    assign magnetron = magnetron_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - directed self-checking bench for microwave_timer
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1hz = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic       enablen, magnetron, alarm;

    int tests_run = 0;
    int tests_failed = 0;

    microwave_timer #(.ALARM_TICKS(3)) dut (
        .clk(clk), .rst(rst), .D(D), .loadn(loadn), .pgt_1hz(pgt_1hz),
        .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .enablen(enablen), .magnetron(magnetron), .alarm(alarm)
    );

    always #5 clk = ~clk;

    wire [11:0] digits = {min_ones, sec_tens, sec_ones};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        D = d;
        loadn = 1'b0;
        step();
        step();
        loadn = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic pulse_tick();
        pgt_1hz = 1'b1; step(); pgt_1hz = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        tests_run++;
        if ({digits, enablen, magnetron, alarm} !== 15'h0) begin
            tests_failed++;
            $display("FAIL reset: digits=%h en=%b mag=%b alarm=%b, required 000/0/0/0", digits, enablen, magnetron, alarm);
        end
    endtask

    task automatic test_load();
        press(4'd1);
        tests_run++;
        if (digits !== 12'h001) begin
            tests_failed++;
            $display("FAIL load_first: digits=%h, required 001", digits);
        end
        press(4'd3);
        press(4'd0);
        tests_run++;
        if (digits !== 12'h130 || enablen !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_130: digits=%h en=%b, required 130/0", digits, enablen);
        end
    endtask

    task automatic test_reject();
        pulse_clear();
        tests_run++;
        if (digits !== 12'h000) begin
            tests_failed++;
            $display("FAIL clear_idle: digits=%h, required 000", digits);
        end
        press(4'd7);
        press(4'd8);
        tests_run++;
        if (digits !== 12'h007) begin
            tests_failed++;
            $display("FAIL reject_gt5: digits=%h, required 007", digits);
        end
        pulse_clear();
        press(4'd4);
        press(4'hC);
        tests_run++;
        if (digits !== 12'h004) begin
            tests_failed++;
            $display("FAIL reject_gt9: digits=%h, required 004", digits);
        end
    endtask

    task automatic test_countdown();
        pulse_clear();
        press(4'd0);
        press(4'd2);
        pulse_start();
        tests_run++;
        if (magnetron !== 1'b1 || enablen !== 1'b1 || digits !== 12'h002) begin
            tests_failed++;
            $display("FAIL run_start: mag=%b en=%b digits=%h, required 1/1/002", magnetron, enablen, digits);
        end
        pulse_tick();
        tests_run++;
        if (digits !== 12'h001 || alarm !== 1'b0) begin
            tests_failed++;
            $display("FAIL tick_001: digits=%h alarm=%b, required 001/0", digits, alarm);
        end
        pulse_tick();
        tests_run++;
        if (digits !== 12'h000 || alarm !== 1'b1 || magnetron !== 1'b0 || enablen !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_entry: digits=%h alarm=%b mag=%b en=%b, required 000/1/0/1", digits, alarm, magnetron, enablen);
        end
        pulse_tick();
        pulse_tick();
        tests_run++;
        if (alarm !== 1'b1) begin
            tests_failed++;
            $display("FAIL alarm_hold: alarm=%b after 2 ticks, required 1", alarm);
        end
        pulse_tick();
        tests_run++;
        if (alarm !== 1'b0 || enablen !== 1'b0 || digits !== 12'h000) begin
            tests_failed++;
            $display("FAIL alarm_end: alarm=%b en=%b digits=%h, required 0/0/000", alarm, enablen, digits);
        end
    endtask

    task automatic test_borrow_and_door();
        press(4'd1);
        press(4'd0);
        press(4'd0);
        pulse_start();
        pulse_tick();
        tests_run++;
        if (digits !== 12'h059) begin
            tests_failed++;
            $display("FAIL borrow: digits=%h, required 059", digits);
        end
        for (int i = 0; i < 14; i++) pulse_tick();
        tests_run++;
        if (digits !== 12'h045) begin
            tests_failed++;
            $display("FAIL count_045: digits=%h, required 045", digits);
        end
        door_closed = 1'b0;
        pulse_tick();
        pulse_tick();
        tests_run++;
        if (digits !== 12'h045 || magnetron !== 1'b0 || enablen !== 1'b1) begin
            tests_failed++;
            $display("FAIL door_pause: digits=%h mag=%b en=%b, required 045/0/1", digits, magnetron, enablen);
        end
        pulse_start();
        tests_run++;
        if (magnetron !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_door_open_paused: mag=%b, required 0", magnetron);
        end
        door_closed = 1'b1;
        pulse_start();
        pulse_tick();
        tests_run++;
        if (digits !== 12'h044 || magnetron !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume: digits=%h mag=%b, required 044/1", digits, magnetron);
        end
    endtask

    task automatic test_same_cycle();
        stop = 1'b1; start = 1'b1; pgt_1hz = 1'b1;
        step();
        stop = 1'b0; start = 1'b0; pgt_1hz = 1'b0;
        tests_run++;
        if (digits !== 12'h044 || magnetron !== 1'b0 || enablen !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_priority: digits=%h mag=%b en=%b, required 044/0/1", digits, magnetron, enablen);
        end
        pulse_stop();
        tests_run++;
        if (digits !== 12'h044 || enablen !== 1'b0) begin
            tests_failed++;
            $display("FAIL paused_stop: digits=%h en=%b, required 044/0", digits, enablen);
        end
    endtask

    task automatic test_start_ignored();
        pulse_clear();
        pulse_start();
        tests_run++;
        if (magnetron !== 1'b0 || enablen !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_zero: mag=%b en=%b, required 0/0", magnetron, enablen);
        end
        press(4'd5);
        door_closed = 1'b0;
        pulse_start();
        tests_run++;
        if (magnetron !== 1'b0 || enablen !== 1'b0 || digits !== 12'h005) begin
            tests_failed++;
            $display("FAIL start_door_open: mag=%b en=%b digits=%h, required 0/0/005", magnetron, enablen, digits);
        end
        door_closed = 1'b1;
    endtask

    task automatic test_done_stop();
        pulse_clear();
        press(4'd1);
        pulse_start();
        pulse_tick();
        pulse_stop();
        tests_run++;
        if (alarm !== 1'b0 || enablen !== 1'b0 || digits !== 12'h000) begin
            tests_failed++;
            $display("FAIL done_stop: alarm=%b en=%b digits=%h, required 0/0/000", alarm, enablen, digits);
        end
    endtask

    task automatic test_reset_mid_run();
        press(4'd9);
        pulse_start();
        pulse_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if ({digits, enablen, magnetron, alarm} !== 15'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: digits=%h en=%b mag=%b alarm=%b, required 000/0/0/0", digits, enablen, magnetron, alarm);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reject();
        test_countdown();
        test_borrow_and_door();
        test_same_cycle();
        test_start_ignored();
        test_done_stop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
